// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions: bus widths, response codes and the crossbar FSM state type.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_RESP,
        WR_REQ,
        WR_RESP
    } xbar_state_t;

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational address decoder: maps an address onto one of NUM_SLV windows, lowest index first.
module axi_addr_decoder
    import axi_pkg::*;
#(
    parameter int NUM_SLV = 3,
    parameter logic [NUM_SLV*AXI_ADDR_W-1:0] SLV_BASE = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
    parameter logic [NUM_SLV*AXI_ADDR_W-1:0] SLV_SIZE = {32'h0000_0010, 32'h0000_0008, 32'h0800_0000},
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]      sel,
    output logic                  miss
);

    // Window end is formed one bit wider so a window touching 2^32 cannot wrap.
    function automatic logic in_window(input logic [AXI_ADDR_W-1:0] a, input int idx);
        logic [AXI_ADDR_W:0] lo;
        logic [AXI_ADDR_W:0] hi;
        lo = {1'b0, SLV_BASE[idx*AXI_ADDR_W +: AXI_ADDR_W]};
        hi = lo + {1'b0, SLV_SIZE[idx*AXI_ADDR_W +: AXI_ADDR_W]};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    always_comb begin
        sel  = '0;
        miss = 1'b1;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (in_window(addr, i)) begin
                sel  = SEL_W'(i);
                miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-to-N AXI-lite router with a single outstanding transaction and DECERR for unmapped addresses.
module axi_lite_xbar
    import axi_pkg::*;
#(
    parameter int NUM_SLV = 3,
    parameter logic [NUM_SLV*AXI_ADDR_W-1:0] SLV_BASE = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
    parameter logic [NUM_SLV*AXI_ADDR_W-1:0] SLV_SIZE = {32'h0000_0010, 32'h0000_0008, 32'h0800_0000},
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [AXI_ADDR_W-1:0]                 m_araddr,
    input  logic                                  m_arvalid,
    output logic                                  m_arready,
    output logic [AXI_DATA_W-1:0]                 m_rdata,
    output logic [AXI_RESP_W-1:0]                 m_rresp,
    output logic                                  m_rvalid,
    input  logic                                  m_rready,
    input  logic [AXI_ADDR_W-1:0]                 m_awaddr,
    input  logic                                  m_awvalid,
    output logic                                  m_awready,
    input  logic [AXI_DATA_W-1:0]                 m_wdata,
    input  logic [AXI_STRB_W-1:0]                 m_wstrb,
    input  logic                                  m_wvalid,
    output logic                                  m_wready,
    output logic [AXI_RESP_W-1:0]                 m_bresp,
    output logic                                  m_bvalid,
    input  logic                                  m_bready,
    output logic [NUM_SLV-1:0][AXI_ADDR_W-1:0]    s_araddr,
    output logic [NUM_SLV-1:0]                    s_arvalid,
    input  logic [NUM_SLV-1:0]                    s_arready,
    input  logic [NUM_SLV-1:0][AXI_DATA_W-1:0]    s_rdata,
    input  logic [NUM_SLV-1:0][AXI_RESP_W-1:0]    s_rresp,
    input  logic [NUM_SLV-1:0]                    s_rvalid,
    output logic [NUM_SLV-1:0]                    s_rready,
    output logic [NUM_SLV-1:0][AXI_ADDR_W-1:0]    s_awaddr,
    output logic [NUM_SLV-1:0]                    s_awvalid,
    input  logic [NUM_SLV-1:0]                    s_awready,
    output logic [NUM_SLV-1:0][AXI_DATA_W-1:0]    s_wdata,
    output logic [NUM_SLV-1:0][AXI_STRB_W-1:0]    s_wstrb,
    output logic [NUM_SLV-1:0]                    s_wvalid,
    input  logic [NUM_SLV-1:0]                    s_wready,
    input  logic [NUM_SLV-1:0][AXI_RESP_W-1:0]    s_bresp,
    input  logic [NUM_SLV-1:0]                    s_bvalid,
    output logic [NUM_SLV-1:0]                    s_bready
);

    xbar_state_t state, state_n;
    logic [SEL_W-1:0] sel_q, sel_n, ar_sel, aw_sel;
    logic miss_q, miss_n, ar_miss, aw_miss;
    logic aw_done, aw_done_n, w_done, w_done_n;

    axi_addr_decoder #(.NUM_SLV(NUM_SLV), .SLV_BASE(SLV_BASE), .SLV_SIZE(SLV_SIZE)) u_ar_dec (
        .addr(m_araddr), .sel(ar_sel), .miss(ar_miss)
    );

    axi_addr_decoder #(.NUM_SLV(NUM_SLV), .SLV_BASE(SLV_BASE), .SLV_SIZE(SLV_SIZE)) u_aw_dec (
        .addr(m_awaddr), .sel(aw_sel), .miss(aw_miss)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            miss_q  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            sel_q   <= sel_n;
            miss_q  <= miss_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // All outputs derive from the registered state, so an async reset clears them immediately.
    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        miss_n    = miss_q;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bresp   = '0;
        m_bvalid  = 1'b0;
        s_araddr  = '0;
        s_arvalid = '0;
        s_rready  = '0;
        s_awaddr  = '0;
        s_awvalid = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = '0;
        s_bready  = '0;

        case (state)
            IDLE: begin
                if (m_arvalid) begin
                    sel_n   = ar_sel;
                    miss_n  = ar_miss;
                    state_n = RD_ADDR;
                end else if (m_awvalid) begin
                    sel_n     = aw_sel;
                    miss_n    = aw_miss;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = WR_REQ;
                end
            end
            RD_ADDR: begin
                if (miss_q) begin
                    m_arready = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            s_arvalid[i] = m_arvalid;
                            s_araddr[i]  = m_araddr;
                            m_arready    = s_arready[i];
                        end
                    end
                end
                if (m_arvalid && m_arready) state_n = RD_RESP;
            end
            RD_RESP: begin
                if (miss_q) begin
                    m_rvalid = 1'b1;
                    m_rresp  = AXI_RESP_DECERR;
                end else begin
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            m_rvalid    = s_rvalid[i];
                            m_rdata     = s_rdata[i];
                            m_rresp     = s_rresp[i];
                            s_rready[i] = m_rready;
                        end
                    end
                end
                if (m_rvalid && m_rready) state_n = IDLE;
            end
            WR_REQ: begin
                // AW and W complete independently; each is masked once its beat has been taken.
                if (miss_q) begin
                    m_awready = ~aw_done;
                    m_wready  = ~w_done;
                end else begin
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            s_awvalid[i] = m_awvalid & ~aw_done;
                            s_awaddr[i]  = m_awaddr;
                            s_wvalid[i]  = m_wvalid & ~w_done;
                            s_wdata[i]   = m_wdata;
                            s_wstrb[i]   = m_wstrb;
                            m_awready    = s_awready[i] & ~aw_done;
                            m_wready     = s_wready[i] & ~w_done;
                        end
                    end
                end
                if (m_awvalid && m_awready) aw_done_n = 1'b1;
                if (m_wvalid && m_wready) w_done_n = 1'b1;
                if (aw_done_n && w_done_n) state_n = WR_RESP;
            end
            WR_RESP: begin
                if (miss_q) begin
                    m_bvalid = 1'b1;
                    m_bresp  = AXI_RESP_DECERR;
                end else begin
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (sel_q == SEL_W'(i)) begin
                            m_bvalid    = s_bvalid[i];
                            m_bresp     = s_bresp[i];
                            s_bready[i] = m_bready;
                        end
                    end
                end
                if (m_bvalid && m_bready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Scoreboard bench for axi_lite_xbar: directed master transactions against behavioural slaves.
module tb_axi_lite_xbar;
    import axi_pkg::*;

    localparam int NS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    logic [NS-1:0][31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [NS-1:0][1:0]  s_rresp, s_bresp;
    logic [NS-1:0][3:0]  s_wstrb;
    logic [NS-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NS-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

    axi_lite_xbar dut (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
        end
    endtask

    // Behavioural slaves: AR/W always ready, AW ready per aw_rdy, read data after rd_lat cycles.
    logic [31:0] slv_rdata [NS];
    logic [1:0]  slv_rresp [NS];
    logic [1:0]  slv_bresp [NS];
    logic [NS-1:0] aw_rdy;
    int          rd_lat;
    int          rd_cnt [NS];
    bit          rd_pend [NS];
    bit          aw_got [NS];
    bit          w_got [NS];
    int          ar_cyc [NS];
    int          aw_hs [NS];
    int          w_hs [NS];
    logic [31:0] cap_awaddr [NS];
    logic [31:0] cap_wdata [NS];
    logic [3:0]  cap_wstrb [NS];
    int          arrdy_cnt = 0;

    assign s_arready = '1;
    assign s_wready  = '1;
    assign s_awready = aw_rdy;

    // Synchronous reset so a slave still holds rvalid at the instant rst_n falls.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n) begin
                s_rvalid[i] <= 1'b0;
                s_bvalid[i] <= 1'b0;
                s_rdata[i]  <= '0;
                s_rresp[i]  <= '0;
                s_bresp[i]  <= '0;
                rd_pend[i]  <= 1'b0;
                rd_cnt[i]   <= 0;
                aw_got[i]   <= 1'b0;
                w_got[i]    <= 1'b0;
                ar_cyc[i]   <= 0;
                aw_hs[i]    <= 0;
                w_hs[i]     <= 0;
            end else begin
                if (s_arvalid[i]) ar_cyc[i] <= ar_cyc[i] + 1;
                if (s_rvalid[i] && s_rready[i]) s_rvalid[i] <= 1'b0;
                if (s_arvalid[i] && s_arready[i]) begin
                    rd_pend[i] <= 1'b1;
                    rd_cnt[i]  <= rd_lat;
                end else if (rd_pend[i]) begin
                    if (rd_cnt[i] <= 1) begin
                        rd_pend[i]  <= 1'b0;
                        s_rvalid[i] <= 1'b1;
                        s_rdata[i]  <= slv_rdata[i];
                        s_rresp[i]  <= slv_rresp[i];
                    end else begin
                        rd_cnt[i] <= rd_cnt[i] - 1;
                    end
                end
                if (s_awvalid[i] && s_awready[i]) begin
                    aw_hs[i]      <= aw_hs[i] + 1;
                    cap_awaddr[i] <= s_awaddr[i];
                end
                if (s_wvalid[i] && s_wready[i]) begin
                    w_hs[i]      <= w_hs[i] + 1;
                    cap_wdata[i] <= s_wdata[i];
                    cap_wstrb[i] <= s_wstrb[i];
                end
                if (s_bvalid[i]) begin
                    if (s_bready[i]) s_bvalid[i] <= 1'b0;
                end else if ((aw_got[i] || (s_awvalid[i] && s_awready[i])) &&
                             (w_got[i] || (s_wvalid[i] && s_wready[i]))) begin
                    s_bvalid[i] <= 1'b1;
                    s_bresp[i]  <= slv_bresp[i];
                    aw_got[i]   <= 1'b0;
                    w_got[i]    <= 1'b0;
                end else begin
                    if (s_awvalid[i] && s_awready[i]) aw_got[i] <= 1'b1;
                    if (s_wvalid[i] && s_wready[i]) w_got[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (m_arready) arrdy_cnt <= arrdy_cnt + 1;

    // Scoreboard monitor: every master-side response handshake pops and checks one entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (m_rvalid && m_rready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got R rdata=0x%08h rresp=%0d, required no response", m_rdata, m_rresp);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_order_kind", 32'(1'b0), 32'(e.wr));
                    chk("rdata", m_rdata, e.data);
                    chk("rresp", 32'(m_rresp), 32'(e.resp));
                end
            end
            if (m_bvalid && m_bready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got B bresp=%0d, required no response", m_bresp);
                end else begin
                    e = exp_q.pop_front();
                    chk("b_order_kind", 32'(1'b1), 32'(e.wr));
                    chk("bresp", 32'(m_bresp), 32'(e.resp));
                end
            end
        end
    end

    task automatic push(input bit wr, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.wr = wr;
        e.data = data;
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int ch, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            case (ch)
                0:       seen = m_arvalid && m_arready;
                1:       seen = m_rvalid && m_rready;
                default: seen = m_bvalid && m_bready;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no handshake in 200 cycles, required one", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_txn(input logic [31:0] a);
        m_araddr  = a;
        m_arvalid = 1'b1;
        wait_hs(0, "ar_handshake");
        m_arvalid = 1'b0;
        m_araddr  = '0;
        wait_hs(1, "r_handshake");
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input bit hold);
        bit awd = 1'b0;
        bit wd = 1'b0;
        m_wdata  = d;
        m_wstrb  = s;
        m_wvalid = 1'b1;
        repeat (lead) begin
            @(posedge clk);
            #1;
        end
        m_awaddr  = a;
        m_awvalid = 1'b1;
        for (int n = 0; n < 100 && !(awd && wd); n++) begin
            @(negedge clk);
            if (m_awvalid && m_awready) awd = 1'b1;
            if (m_wvalid && m_wready) wd = 1'b1;
            @(posedge clk);
            #1;
            if (!hold) begin
                if (awd) m_awvalid = 1'b0;
                if (wd) m_wvalid = 1'b0;
            end
        end
        if (!(awd && wd)) begin
            checks++;
            errors++;
            $display("FAIL aw_w_handshake: got aw=%0d w=%0d in 100 cycles, required both", awd, wd);
        end
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        wait_hs(2, "b_handshake");
    endtask

    initial begin
        int a0, a1, a2, r0, aw1, w1;
        bit rv_seen;
        rst_n = 1'b0;
        m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b1;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
        m_bready = 1'b1;
        aw_rdy = '1;
        rd_lat = 3;
        for (int i = 0; i < NS; i++) begin
            slv_rdata[i] = '0;
            slv_rresp[i] = AXI_RESP_OKAY;
            slv_bresp[i] = AXI_RESP_OKAY;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_ctrl", 32'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 32'(0));
        chk("rst_s_ctrl", 32'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 32'(0));
        chk("rst_m_data", m_rdata ^ 32'({m_rresp, m_bresp}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read from sram, 3-cycle slave latency.
        slv_rdata[0] = 32'hdead_beef;
        a0 = ar_cyc[0]; a1 = ar_cyc[1]; a2 = ar_cyc[2]; r0 = arrdy_cnt;
        push(1'b0, 32'hdead_beef, AXI_RESP_OKAY);
        rd_txn(32'h8000_0010);
        chk("t1_s0_ar_cycles", ar_cyc[0] - a0, 1);
        chk("t1_other_ar_cycles", (ar_cyc[1] - a1) + (ar_cyc[2] - a2), 0);
        chk("t1_arready_cycles", arrdy_cnt - r0, 1);

        // Write to uart with W leading AW and AW stalled by the slave; master holds both valids.
        aw_rdy[1] = 1'b0;
        aw1 = aw_hs[1]; w1 = w_hs[1];
        push(1'b1, 32'h0, AXI_RESP_OKAY);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                aw_rdy[1] = 1'b1;
            end
        join_none
        wr_txn(32'ha000_03f8, 32'h0000_0041, 4'b0001, 2, 1'b1);
        chk("t2_s1_aw_count", aw_hs[1] - aw1, 1);
        chk("t2_s1_w_count", w_hs[1] - w1, 1);
        chk("t2_s1_awaddr", cap_awaddr[1], 32'ha000_03f8);
        chk("t2_s1_wdata", cap_wdata[1], 32'h0000_0041);
        chk("t2_s1_wstrb", 32'(cap_wstrb[1]), 32'(4'b0001));

        // Unmapped read.
        a0 = ar_cyc[0]; a1 = ar_cyc[1]; a2 = ar_cyc[2]; r0 = arrdy_cnt;
        push(1'b0, 32'h0, AXI_RESP_DECERR);
        rd_txn(32'h0000_1000);
        chk("t3_arready_cycles", arrdy_cnt - r0, 1);
        chk("t3_no_s_arvalid", (ar_cyc[0] - a0) + (ar_cyc[1] - a1) + (ar_cyc[2] - a2), 0);

        // AR and AW in the same cycle: R must come before B.
        slv_rdata[0] = 32'h1111_2222;
        push(1'b0, 32'h1111_2222, AXI_RESP_OKAY);
        push(1'b1, 32'h0, AXI_RESP_OKAY);
        fork
            rd_txn(32'h8000_0100);
            wr_txn(32'h8000_0200, 32'h5555_aaaa, 4'hf, 0, 1'b0);
        join
        chk("t4_s0_awaddr", cap_awaddr[0], 32'h8000_0200);
        chk("t4_s0_wdata", cap_wdata[0], 32'h5555_aaaa);

        // Async reset while the slave holds rvalid in RD_RESP.
        slv_rdata[0] = 32'h7777_0000;
        m_rready = 1'b0;
        m_araddr = 32'h8000_0020;
        m_arvalid = 1'b1;
        wait_hs(0, "t5_ar_handshake");
        m_arvalid = 1'b0;
        rv_seen = 1'b0;
        for (int n = 0; n < 20 && !rv_seen; n++) begin
            @(negedge clk);
            rv_seen = s_rvalid[0];
        end
        chk("t5_pre_reset_rvalid", 32'(m_rvalid), 32'(1));
        #2;
        rst_n = 1'b0;
        m_rready = 1'b1;
        #1;
        chk("t5_rvalid_async", 32'(m_rvalid), 32'(0));
        chk("t5_rdata_async", m_rdata, 32'h0);
        chk("t5_s_rready_async", 32'(s_rready), 32'(0));
        chk("t5_other_ctrl", 32'({m_arready, m_awready, m_wready, m_bvalid}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        slv_rdata[0] = 32'h0bad_f00d;
        push(1'b0, 32'h0bad_f00d, AXI_RESP_OKAY);
        rd_txn(32'h8000_0040);

        // Window boundaries and response pass-through.
        slv_rdata[0] = 32'h1234_5678;
        push(1'b0, 32'h1234_5678, AXI_RESP_OKAY);
        rd_txn(32'h87ff_fffc);
        push(1'b0, 32'h0, AXI_RESP_DECERR);
        rd_txn(32'h8800_0000);
        slv_rdata[2] = 32'hcafe_0057;
        slv_rresp[2] = AXI_RESP_SLVERR;
        push(1'b0, 32'hcafe_0057, AXI_RESP_SLVERR);
        rd_txn(32'ha000_0057);
        push(1'b0, 32'h0, AXI_RESP_DECERR);
        rd_txn(32'ha000_0058);
        push(1'b0, 32'h0, AXI_RESP_DECERR);
        rd_txn(32'ha000_0047);
        slv_bresp[2] = AXI_RESP_SLVERR;
        push(1'b1, 32'h0, AXI_RESP_SLVERR);
        wr_txn(32'ha000_0048, 32'h0000_00aa, 4'b0011, 0, 1'b0);
        chk("t6_s2_awaddr", cap_awaddr[2], 32'ha000_0048);
        push(1'b1, 32'h0, AXI_RESP_DECERR);
        wr_txn(32'h9000_0000, 32'h0000_00bb, 4'b1111, 1, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
